// File: rtl/lcd_sched_pkg.sv
// Shared opcode constants, scheduler state encoding and the opcode legality check
// for the LCD command scheduler.
package lcd_sched_pkg;

  localparam logic [3:0] CMD_WRITE = 4'd0;
  localparam logic [3:0] CMD_UP    = 4'd1;
  localparam logic [3:0] CMD_DOWN  = 4'd2;
  localparam logic [3:0] CMD_LEFT  = 4'd3;
  localparam logic [3:0] CMD_RIGHT = 4'd4;
  localparam logic [3:0] CMD_MAX   = 4'd5;
  localparam logic [3:0] CMD_MIN   = 4'd6;
  localparam logic [3:0] CMD_AVG   = 4'd7;

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DRAIN,
    S_DONE
  } state_e;

  // Opcodes 8..15 are outside the controller's command set.
  function automatic logic is_legal(input logic [3:0] opcode);
    return !opcode[3];
  endfunction

endpackage

// File: rtl/lcd_cmd_fifo.sv
// Synchronous command FIFO with flush; head shows the oldest entry while not empty.
module lcd_cmd_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]   FULL_CNT = DEPTH[AW:0];
  localparam logic [AW:0]   CNT_ONE  = 1;
  localparam logic [AW-1:0] PTR_ONE  = 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = din;
        wr_ptr_d        = wr_ptr_q + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
    mem_q <= mem_d;
  end

endmodule

// File: rtl/lcd_cmd_sched.sv
// Host command scheduler for the LCD controller: buffers, filters and issues one command at a
// time. Define LCD_SCHED_PERF_EN to add the perf_issued/perf_stall counters.
module lcd_cmd_sched
  import lcd_sched_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       host_cmd,
  input  logic             host_valid,
  output logic             host_ready,
  output logic [3:0]       lcd_cmd,
  output logic             lcd_cmd_valid,
  input  logic             lcd_busy,
  input  logic             lcd_done,
  output logic             sched_done,
  output logic [CNT_W-1:0] illegal_cnt,
  output logic             err_timeout
`ifdef LCD_SCHED_PERF_EN
  ,
  output logic [CNT_W-1:0] perf_issued,
  output logic [CNT_W-1:0] perf_stall
`endif
);

  localparam logic [CNT_W-1:0] CNT_ONE    = 1;
  localparam logic [CNT_W-1:0] TIMEOUT_M1 = CNT_W'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [3:0]       lcd_cmd_q, lcd_cmd_d;
  logic             lcd_cmd_valid_q, lcd_cmd_valid_d;
  logic [CNT_W-1:0] illegal_cnt_q, illegal_cnt_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             err_timeout_q, err_timeout_d;

  logic       fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
  logic [3:0] fifo_head;
  logic       host_xfer;

  assign host_ready = !fifo_full && (state_q inside {S_IDLE, S_ISSUE, S_WAIT});
  assign host_xfer  = host_valid && host_ready;
  assign fifo_push  = host_xfer && is_legal(host_cmd);

  lcd_cmd_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(4)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (fifo_push),
    .pop  (fifo_pop),
    .flush(fifo_flush),
    .din  (host_cmd),
    .head (fifo_head),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  always_comb begin
    illegal_cnt_d = illegal_cnt_q;
    if (host_xfer && !is_legal(host_cmd) && (illegal_cnt_q != '1)) begin
      illegal_cnt_d = illegal_cnt_q + CNT_ONE;
    end
  end

  always_comb begin
    state_d         = state_q;
    lcd_cmd_d       = lcd_cmd_q;
    lcd_cmd_valid_d = lcd_cmd_valid_q;
    wait_cnt_d      = wait_cnt_q;
    err_timeout_d   = err_timeout_q;
    fifo_pop        = 1'b0;
    fifo_flush      = 1'b0;
    case (state_q)
      S_INIT: begin
        if (!lcd_busy) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (!fifo_empty && !lcd_busy) begin
          fifo_pop        = 1'b1;
          lcd_cmd_d       = fifo_head;
          lcd_cmd_valid_d = 1'b1;
          state_d         = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!lcd_busy) begin
          lcd_cmd_valid_d = 1'b0;
          wait_cnt_d      = '0;
          state_d         = (lcd_cmd_q == CMD_WRITE) ? S_DRAIN : S_WAIT;
        end
      end
      S_WAIT: begin
        // Busy from the controller lags acceptance by a cycle, so the first cycle is blind.
        if ((wait_cnt_q != '0) && !lcd_busy) begin
          state_d = S_IDLE;
        end else if (wait_cnt_q == TIMEOUT_M1) begin
          err_timeout_d = 1'b1;
          state_d       = S_IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_ONE;
        end
      end
      S_DRAIN: begin
        if (lcd_done) begin
          fifo_flush = 1'b1;
          state_d    = S_DONE;
        end
      end
      S_DONE:  state_d = S_DONE;
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_INIT;
      lcd_cmd_q       <= '0;
      lcd_cmd_valid_q <= 1'b0;
      illegal_cnt_q   <= '0;
      wait_cnt_q      <= '0;
      err_timeout_q   <= 1'b0;
    end else begin
      state_q         <= state_d;
      lcd_cmd_q       <= lcd_cmd_d;
      lcd_cmd_valid_q <= lcd_cmd_valid_d;
      illegal_cnt_q   <= illegal_cnt_d;
      wait_cnt_q      <= wait_cnt_d;
      err_timeout_q   <= err_timeout_d;
    end
  end

  assign lcd_cmd       = lcd_cmd_q;
  assign lcd_cmd_valid = lcd_cmd_valid_q;
  assign sched_done    = (state_q == S_DONE);
  assign illegal_cnt   = illegal_cnt_q;
  assign err_timeout   = err_timeout_q;

`ifdef LCD_SCHED_PERF_EN
  logic [CNT_W-1:0] perf_issued_q, perf_issued_d;
  logic [CNT_W-1:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_issued_d = perf_issued_q;
    perf_stall_d  = perf_stall_q;
    if ((state_q == S_ISSUE) && !lcd_busy && (perf_issued_q != '1)) begin
      perf_issued_d = perf_issued_q + CNT_ONE;
    end
    if ((state_q == S_IDLE) && !fifo_empty && lcd_busy && (perf_stall_q != '1)) begin
      perf_stall_d = perf_stall_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_issued_q <= '0;
      perf_stall_q  <= '0;
    end else begin
      perf_issued_q <= perf_issued_d;
      perf_stall_q  <= perf_stall_d;
    end
  end

  assign perf_issued = perf_issued_q;
  assign perf_stall  = perf_stall_q;
`endif

endmodule

// File: tb/tb_lcd_cmd_sched.sv
// Directed bench for lcd_cmd_sched: vector table for single commands plus sequences for
// FIFO-full, write drain, flush, timeout and reset corner cases.
module tb_lcd_cmd_sched;

  localparam int unsigned FIFO_DEPTH = 8;
  localparam int unsigned CNT_W      = 16;
  localparam int unsigned TIMEOUT    = 255;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [3:0]       host_cmd = '0;
  logic             host_valid = 1'b0;
  logic             host_ready;
  logic [3:0]       lcd_cmd;
  logic             lcd_cmd_valid;
  logic             lcd_busy = 1'b1;
  logic             lcd_done = 1'b0;
  logic             sched_done;
  logic [CNT_W-1:0] illegal_cnt;
  logic             err_timeout;
`ifdef LCD_SCHED_PERF_EN
  logic [CNT_W-1:0] perf_issued;
  logic [CNT_W-1:0] perf_stall;
`endif

  always #5 clk = ~clk;

  lcd_cmd_sched #(
    .FIFO_DEPTH(FIFO_DEPTH),
    .CNT_W     (CNT_W),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .host_cmd     (host_cmd),
    .host_valid   (host_valid),
    .host_ready   (host_ready),
    .lcd_cmd      (lcd_cmd),
    .lcd_cmd_valid(lcd_cmd_valid),
    .lcd_busy     (lcd_busy),
    .lcd_done     (lcd_done),
    .sched_done   (sched_done),
    .illegal_cnt  (illegal_cnt),
    .err_timeout  (err_timeout)
`ifdef LCD_SCHED_PERF_EN
    ,
    .perf_issued  (perf_issued),
    .perf_stall   (perf_stall)
`endif
  );

  int checks   = 0;
  int failures = 0;

  // Controller model: busy rises one cycle after acceptance for one cycle; done follows a write.
  logic [3:0] acc_q[$];
  bit         model_en   = 1'b0;
  int         phase      = 0;
  bit         last_write = 1'b0;

  typedef struct {
    logic [3:0] cmd;
    bit         issue;
    int         ill;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic step();
    logic       acc;
    logic [3:0] c;
    acc = model_en && lcd_cmd_valid && !lcd_busy;
    c   = lcd_cmd;
    @(posedge clk);
    #1;
    lcd_done = 1'b0;
    if (model_en) begin
      if (acc) begin
        acc_q.push_back(c);
        last_write = (c == 4'd0);
        phase      = 1;
      end else if (phase == 1) begin
        lcd_busy = 1'b1;
        phase    = 2;
      end else if (phase == 2) begin
        lcd_busy = 1'b0;
        lcd_done = last_write;
        phase    = 0;
      end
    end
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    host_valid = 1'b0;
    lcd_done   = 1'b0;
    model_en   = 1'b0;
    phase      = 0;
    step();
    chk("rst_host_ready", host_ready, 0);
    chk("rst_lcd_cmd", lcd_cmd, 0);
    chk("rst_lcd_cmd_valid", lcd_cmd_valid, 0);
    chk("rst_sched_done", sched_done, 0);
    chk("rst_illegal_cnt", illegal_cnt, 0);
    chk("rst_err_timeout", err_timeout, 0);
    rst = 1'b0;
  endtask

  task automatic leave_init();
    lcd_busy = 1'b0;
    chk("init_ready_low", host_ready, 0);
    step();
    chk("init_ready_rise", host_ready, 1);
  endtask

  task automatic push(input logic [3:0] c, input string name);
    chk(name, host_ready, 1);
    host_cmd   = c;
    host_valid = 1'b1;
    step();
    host_valid = 1'b0;
  endtask

  initial begin
    vec_t       vecs[6];
    logic [3:0] fullv[9];
    logic [3:0] seqv[4];
    int         n0;
    int         bad;
    bit         found;

    vecs[0] = '{cmd: 4'd9,  issue: 1'b0, ill: 1};
    vecs[1] = '{cmd: 4'd3,  issue: 1'b1, ill: 1};
    vecs[2] = '{cmd: 4'd15, issue: 1'b0, ill: 2};
    vecs[3] = '{cmd: 4'd6,  issue: 1'b1, ill: 2};
    vecs[4] = '{cmd: 4'd8,  issue: 1'b0, ill: 3};
    vecs[5] = '{cmd: 4'd2,  issue: 1'b1, ill: 3};
    fullv   = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd1, 4'd2};
    seqv    = '{4'd5, 4'd1, 4'd7, 4'd0};

    // Reset, then S_INIT held by busy for 65 cycles.
    lcd_busy = 1'b1;
    do_reset();
    bad = 0;
    for (int i = 0; i < 65; i++) begin
      step();
      if (host_ready || lcd_cmd_valid) bad++;
    end
    chk("init_quiet", bad, 0);
    leave_init();

    // Single-command vectors with the controller model.
    model_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      n0 = acc_q.size();
      push(vecs[i].cmd, $sformatf("tbl%0d_ready", i));
      step();
      chk($sformatf("tbl%0d_valid", i), lcd_cmd_valid, vecs[i].issue);
      if (vecs[i].issue) chk($sformatf("tbl%0d_cmd", i), lcd_cmd, vecs[i].cmd);
      repeat (8) step();
      chk($sformatf("tbl%0d_issued", i), acc_q.size() - n0, vecs[i].issue);
      if (vecs[i].issue) chk($sformatf("tbl%0d_acc", i), acc_q[$], vecs[i].cmd);
      chk($sformatf("tbl%0d_illegal", i), illegal_cnt, vecs[i].ill);
    end

    // Fill the FIFO while busy; the 9th waits for the first pop.
    model_en = 1'b0;
    lcd_busy = 1'b1;
    for (int i = 0; i < 8; i++) push(fullv[i], $sformatf("fill%0d_ready", i));
    chk("full_ready_low", host_ready, 0);
    host_cmd   = fullv[8];
    host_valid = 1'b1;
    repeat (3) step();
    chk("full_ready_held", host_ready, 0);
    lcd_busy = 1'b0;
    step();
    lcd_busy = 1'b1;
    chk("full_pop_valid", lcd_cmd_valid, 1);
    chk("full_pop_cmd", lcd_cmd, fullv[0]);
    chk("full_pop_ready", host_ready, 1);
    step();
    host_valid = 1'b0;
    chk("full_again", host_ready, 0);
    n0       = acc_q.size();
    lcd_busy = 1'b0;
    phase    = 0;
    model_en = 1'b1;
    for (int i = 0; i < 200 && (acc_q.size() - n0) < 9; i++) step();
    repeat (20) step();
    chk("full_drain_count", acc_q.size() - n0, 9);
    for (int i = 0; i < 9; i++) begin
      if (n0 + i < acc_q.size()) chk($sformatf("full_order%0d", i), acc_q[n0 + i], fullv[i]);
    end

    // 5,1,7,0 back-to-back, finishing with write-out.
    n0 = acc_q.size();
    for (int i = 0; i < 4; i++) push(seqv[i], $sformatf("seq%0d_ready", i));
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      step();
      if (lcd_done) begin
        found = 1'b1;
        chk("seq_done_before", sched_done, 0);
        step();
        chk("seq_done_after", sched_done, 1);
      end
    end
    chk("seq_done_seen", found, 1);
    chk("seq_count", acc_q.size() - n0, 4);
    for (int i = 0; i < 4; i++) begin
      if (n0 + i < acc_q.size()) chk($sformatf("seq_order%0d", i), acc_q[n0 + i], seqv[i]);
    end
    chk("seq_done_ready", host_ready, 0);

    // Commands queued behind a write are flushed.
    do_reset();
    leave_init();
    model_en = 1'b1;
    n0       = acc_q.size();
    push(4'd0, "flush_ready0");
    push(4'd2, "flush_ready1");
    push(4'd2, "flush_ready2");
    host_cmd   = 4'd2;
    host_valid = 1'b1;
    bad        = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (host_ready) bad++;
    end
    host_valid = 1'b0;
    chk("flush_count", acc_q.size() - n0, 1);
    if (acc_q.size() > n0) chk("flush_cmd", acc_q[n0], 0);
    chk("flush_sched_done", sched_done, 1);
    chk("flush_ready_low", host_ready, 0);
    chk("flush_no_valid", lcd_cmd_valid, 0);

    // Timeout in S_WAIT, then reset while a command sits in S_ISSUE.
    do_reset();
    leave_init();
    push(4'd12, "to_ready0");
    push(4'd4, "to_ready1");
    step();
    chk("to_valid", lcd_cmd_valid, 1);
    step();
    lcd_busy = 1'b1;
    repeat (254) step();
    chk("to_not_yet", err_timeout, 0);
    step();
    chk("to_flag", err_timeout, 1);
    chk("to_no_valid", lcd_cmd_valid, 0);
    repeat (45) step();
    chk("to_sticky", err_timeout, 1);
    chk("to_illegal", illegal_cnt, 1);
    push(4'd6, "rs_ready");
    lcd_busy = 1'b0;
    step();
    lcd_busy = 1'b1;
    step();
    chk("rs_issue_valid", lcd_cmd_valid, 1);
    chk("rs_issue_cmd", lcd_cmd, 6);
    do_reset();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
